bridge_arbiter: RTL and testbench
=================================

Name: bridge_arbiter

Overview:
- Shares the single bridge DRAM-access port (C_* handshake) between two requesters: req0 = OS transaction engine, req1 = background restock/audit engine.
- Sits between the requesters and bridge.
- Fair two-way round-robin grant; one outstanding bridge transaction at a time.
- Per-transaction timeout so a hung bridge cannot deadlock either requester.

Parameters:
- ADDR_W, 8, DRAM user/record index width (matches C_addr).
- DATA_W, 64, record width (matches C_data_w/C_data_r).
- TIMEOUT_CYC, 1024, max cycles from C_in_valid to C_out_valid before error completion.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- req0_valid  in  1  request pending; held high until req0_ack.
- req0_r_wb  in  1  1 = read, 0 = write.
- req0_addr  in  ADDR_W  record address.
- req0_data_w  in  DATA_W  write data.
- req0_ack  out  1  one-cycle pulse: request accepted; requester may drop or change its inputs next cycle.
- req0_done  out  1  one-cycle pulse: transaction complete.
- req0_err  out  1  valid with req0_done: 1 = timeout.
- req0_data_r  out  DATA_W  read data, valid with req0_done; holds until next done.
- req1_*  same set as req0_*.
- C_in_valid  out  1  one-cycle pulse to bridge.
- C_r_wb  out  1  to bridge.
- C_addr  out  ADDR_W  to bridge.
- C_data_w  out  DATA_W  to bridge.
- C_out_valid  in  1  bridge completion pulse.
- C_data_r  in  DATA_W  bridge read data, valid with C_out_valid.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = 1, so req0 wins the first tie; timeout counter 0.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: if any reqN_valid, at the edge:
  - pick winner: the only valid one, or on tie the one != last_grant;
  - latch r_wb, addr and data_w of the winner;
  - update last_grant; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - C_in_valid = 1; C_r_wb/C_addr/C_data_w driven from the latch.
  - ack of the winner = 1.
  - Go to WAIT; counter cleared.
  - C_addr/C_r_wb/C_data_w hold their latched values until the next ISSUE.
- WAIT:
  - Counter increments each cycle.
  - C_out_valid: capture C_data_r (reads only; writes leave data_r unchanged), err = 0, go to RESP.
  - Counter reaches TIMEOUT_CYC-1 without C_out_valid: err = 1, go to DRAIN.
  - C_out_valid in the timeout cycle itself counts as success.
- RESP (1 cycle): winner done = 1 with its err and data_r; go to IDLE.
- DRAIN:
  - Winner done = 1 with err = 1 in the first DRAIN cycle only.
  - Then wait for C_out_valid, discard its data, go to IDLE.
  - No new issue while in DRAIN.
- Latency: request seen in IDLE → ack 1 cycle later → done 2 cycles after C_out_valid.
  - Back-to-back minimum issue spacing is 4 cycles plus bridge latency.
- Fairness: both held valid → grants strictly alternate 0,1,0,1…
- A valid that drops before ack is ignored if it is not sampled in IDLE; requesters must not do this (protocol violation, no recovery logic).
- C_out_valid outside WAIT/DRAIN is ignored.
- Only one of ack0/ack1, and only one of done0/done1, is ever high in a cycle.
- rst_n low mid-transaction: immediate return to IDLE with all outputs 0; bridge shares rst_n, so no drain is required.

Decomposition:
- Add to the shared Usertype_OS package:
  - arb_state_t enum (IDLE, ISSUE, WAIT, RESP, DRAIN);
  - the ADDR_W/DATA_W defaults as localparams.
- Sub-module rr_pick2: combinational two-way round-robin picker.
  - Inputs: valid[1:0], last_grant.
  - Outputs: grant_onehot, any.

Test Plan:
- req0 read addr 8'h05, bridge returns 64'hDEAD_BEEF_0000_0005 after 20 cycles → one C_in_valid with C_r_wb=1, C_addr=5; req0_ack one cycle after request; req0_done 2 cycles after C_out_valid, data_r matches, err=0; req1 outputs stay 0.
- req0 and req1 assert together, held through 4 transactions → grant order 0,1,0,1; C_addr alternates between the two requesters' addresses; never two C_in_valid without an intervening C_out_valid.
- req1 write addr 8'hFF, data 64'h1234 → C_r_wb=0, C_data_w=64'h1234; req1_done with err=0; req1_data_r unchanged from its previous value.
- Bridge stalled with TIMEOUT_CYC=16 → req0_done with err=1 exactly 16 cycles after ISSUE; a req1 held valid is not acked until the late C_out_valid arrives; that late data is not forwarded.
- rst_n pulled low during WAIT → all outputs 0 asynchronously; after release, a new req1 is granted first (last_grant reset to 1 favours req0 only on a tie) and completes normally.

Source files
------------

// File: rtl/bridge_arbiter_pkg.sv
// Shared types and width defaults for the bridge DRAM-port arbiter.
package bridge_arbiter_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } arb_state_t;
endpackage

// File: rtl/bridge_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester that did
// not win last time is chosen.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant_onehot,
    output logic       any
);
    always_comb begin
        grant_onehot = valid;
        if (valid == 2'b11)
            grant_onehot = last_grant ? 2'b01 : 2'b10;
    end

    assign any = |valid;
endmodule

// File: rtl/bridge_arbiter.sv
// Shares the single bridge C_* port between the OS engine (req0) and the
// restock/audit engine (req1), one outstanding transaction with timeout.
module bridge_arbiter
    import bridge_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_r_wb,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data_w,
    output logic              req0_ack,
    output logic              req0_done,
    output logic              req0_err,
    output logic [DATA_W-1:0] req0_data_r,
    input  logic              req1_valid,
    input  logic              req1_r_wb,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data_w,
    output logic              req1_ack,
    output logic              req1_done,
    output logic              req1_err,
    output logic [DATA_W-1:0] req1_data_r,
    output logic              C_in_valid,
    output logic              C_r_wb,
    output logic [ADDR_W-1:0] C_addr,
    output logic [DATA_W-1:0] C_data_w,
    input  logic              C_out_valid,
    input  logic [DATA_W-1:0] C_data_r
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    // Leaving WAIT from this value is the moment the counter would reach TIMEOUT_CYC-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 2);

    arb_state_t        state;
    logic              last_grant;
    logic              owner;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        grant;
    logic              any_valid;

    rr_pick2 u_pick (
        .valid       ({req1_valid, req0_valid}),
        .last_grant  (last_grant),
        .grant_onehot(grant),
        .any         (any_valid)
    );

    // The C_* request fields double as the request latch and hold until the next issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            cnt         <= '0;
            rsp_data    <= '0;
            C_in_valid  <= 1'b0;
            C_r_wb      <= 1'b0;
            C_addr      <= '0;
            C_data_w    <= '0;
            req0_ack    <= 1'b0;
            req0_done   <= 1'b0;
            req0_err    <= 1'b0;
            req0_data_r <= '0;
            req1_ack    <= 1'b0;
            req1_done   <= 1'b0;
            req1_err    <= 1'b0;
            req1_data_r <= '0;
        end else begin
            C_in_valid <= 1'b0;
            req0_ack   <= 1'b0;
            req1_ack   <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner      <= grant[1];
                        last_grant <= grant[1];
                        C_in_valid <= 1'b1;
                        C_r_wb     <= grant[1] ? req1_r_wb   : req0_r_wb;
                        C_addr     <= grant[1] ? req1_addr   : req0_addr;
                        C_data_w   <= grant[1] ? req1_data_w : req0_data_w;
                        req0_ack   <= grant[0];
                        req1_ack   <= grant[1];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (C_out_valid) begin
                        if (C_r_wb)
                            rsp_data <= C_data_r;
                        state <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        req0_done <= ~owner;
                        req1_done <= owner;
                        req0_err  <= ~owner;
                        req1_err  <= owner;
                        state     <= DRAIN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    req0_done <= ~owner;
                    req1_done <= owner;
                    if (C_r_wb) begin
                        if (owner)
                            req1_data_r <= rsp_data;
                        else
                            req0_data_r <= rsp_data;
                    end
                    state <= IDLE;
                end
                DRAIN: begin
                    if (C_out_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bridge_arbiter.sv
// Self-checking bench for bridge_arbiter: a transaction-level scoreboard plus a
// behavioural bridge with programmable or random latency.
module tb_bridge_arbiter;
    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 64;
    localparam int TIMEOUT_CYC = 16;

    typedef struct {
        logic              r_wb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid = 1'b0, req0_r_wb = 1'b0, req1_valid = 1'b0, req1_r_wb = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
    logic [DATA_W-1:0] req0_data_w = '0, req1_data_w = '0;
    logic req0_ack, req0_done, req0_err, req1_ack, req1_done, req1_err;
    logic [DATA_W-1:0] req0_data_r, req1_data_r;
    logic C_in_valid, C_r_wb;
    logic [ADDR_W-1:0] C_addr;
    logic [DATA_W-1:0] C_data_w;
    logic C_out_valid = 1'b0;
    logic [DATA_W-1:0] C_data_r = '0;

    bridge_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_r_wb  (req0_r_wb),
        .req0_addr  (req0_addr),
        .req0_data_w(req0_data_w),
        .req0_ack   (req0_ack),
        .req0_done  (req0_done),
        .req0_err   (req0_err),
        .req0_data_r(req0_data_r),
        .req1_valid (req1_valid),
        .req1_r_wb  (req1_r_wb),
        .req1_addr  (req1_addr),
        .req1_data_w(req1_data_w),
        .req1_ack   (req1_ack),
        .req1_done  (req1_done),
        .req1_err   (req1_err),
        .req1_data_r(req1_data_r),
        .C_in_valid (C_in_valid),
        .C_r_wb     (C_r_wb),
        .C_addr     (C_addr),
        .C_data_w   (C_data_w),
        .C_out_valid(C_out_valid),
        .C_data_r   (C_data_r)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bridge: answers each C_in_valid after bridge_lat cycles (0 = random 1..18).
    int          bridge_lat = 0;
    bit          salt_random = 1'b0;
    logic [31:0] bridge_salt = 32'hDEAD_BEEF;
    int          br_cnt = 0;
    logic [DATA_W-1:0] br_data = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt      = 0;
            C_out_valid = 1'b0;
            C_data_r    = '0;
        end else begin
            #1;
            C_out_valid = 1'b0;
            C_data_r    = {$urandom, $urandom};
            if (br_cnt > 0) begin
                br_cnt--;
                if (br_cnt == 0) begin
                    C_out_valid = 1'b1;
                    C_data_r    = br_data;
                end
            end
            if (C_in_valid) begin
                br_cnt  = (bridge_lat > 0) ? bridge_lat : int'($urandom_range(1, 18));
                br_data = {(salt_random ? 32'($urandom) : bridge_salt), 24'h0, C_addr};
            end
        end
    end

    int total = 0;
    int bad = 0;

    req_t q0[$];
    req_t q1[$];
    bit          model_last = 1'b1;
    bit          owner = 1'b0;
    bit          txn_open = 1'b0;
    bit          txn_rwb = 1'b0;
    bit          resp_seen = 1'b0;
    bit          bridge_busy = 1'b0;
    int unsigned issue_cyc = 0, resp_cyc = 0, last_resp_cyc = 0;
    int unsigned load_cyc0 = 0, load_cyc1 = 0, ack_cyc0 = 0, ack_cyc1 = 0, ack_gap1 = 0;
    logic [DATA_W-1:0] resp_data = '0, exp_data_r0 = '0, exp_data_r1 = '0;
    int          done_count = 0;
    int          timeouts = 0;
    bit          grant_log[$];
    logic        req1_pulses = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input bit who, input bit r_wb, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data);
        req_t r;
        r.r_wb = r_wb;
        r.addr = addr;
        r.data = data;
        if (who) q1.push_back(r);
        else q0.push_back(r);
    endtask

    // One cycle: score what the DUT shows this cycle, then update requester drive.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            req1_pulses = req1_pulses | req1_ack | req1_done | req1_err;
            if (req0_ack || req1_ack) begin
                bit exp_who;
                bit exp_rwb;
                if (!req0_valid && !req1_valid) checkOutput("ack_no_req", 1, 0);
                exp_who = (req0_valid && req1_valid) ? !model_last : req1_valid;
                exp_rwb = exp_who ? req1_r_wb : req0_r_wb;
                checkOutput("ack_excl", req0_ack & req1_ack, 0);
                checkOutput("ack_who", req1_ack, exp_who);
                checkOutput("issue_with_ack", C_in_valid, 1);
                checkOutput("one_outstanding", bridge_busy, 0);
                checkOutput("c_addr", C_addr, exp_who ? req1_addr : req0_addr);
                checkOutput("c_r_wb", C_r_wb, exp_rwb);
                if (!exp_rwb) checkOutput("c_data_w", C_data_w, exp_who ? req1_data_w : req0_data_w);
                model_last  = exp_who;
                owner       = exp_who;
                issue_cyc   = cyc;
                resp_seen   = 1'b0;
                txn_open    = 1'b1;
                txn_rwb     = exp_rwb;
                bridge_busy = 1'b1;
                grant_log.push_back(exp_who);
                if (exp_who) begin
                    ack_cyc1 = cyc;
                    ack_gap1 = cyc - last_resp_cyc;
                end else begin
                    ack_cyc0 = cyc;
                end
            end else begin
                checkOutput("stray_issue", C_in_valid, 0);
            end
            if (req0_done || req1_done) begin
                bit who;
                bit late;
                who  = req1_done;
                late = !resp_seen;
                checkOutput("done_excl", req0_done & req1_done, 0);
                checkOutput("done_open", txn_open, 1);
                checkOutput("done_who", who, owner);
                checkOutput("done_cyc", cyc, late ? issue_cyc + TIMEOUT_CYC : resp_cyc + 2);
                checkOutput("done_err", who ? req1_err : req0_err, late);
                if (!late && txn_rwb) begin
                    if (who) exp_data_r1 = resp_data;
                    else exp_data_r0 = resp_data;
                end
                checkOutput("data_r0", req0_data_r, exp_data_r0);
                checkOutput("data_r1", req1_data_r, exp_data_r1);
                if (late) timeouts++;
                txn_open = 1'b0;
                done_count++;
            end else begin
                checkOutput("err_without_done", req0_err | req1_err, 0);
            end
            if (C_out_valid) begin
                bridge_busy   = 1'b0;
                last_resp_cyc = cyc;
                if (txn_open && !resp_seen && (cyc - issue_cyc) < TIMEOUT_CYC) begin
                    resp_seen = 1'b1;
                    resp_cyc  = cyc;
                    resp_data = C_data_r;
                end
            end
            if (req0_ack) void'(q0.pop_front());
            if (req1_ack) void'(q1.pop_front());
        end
        if (rst_n && q0.size() > 0) begin
            if (!req0_valid) load_cyc0 = cyc;
            req0_valid  = 1'b1;
            req0_r_wb   = q0[0].r_wb;
            req0_addr   = q0[0].addr;
            req0_data_w = q0[0].data;
        end else begin
            req0_valid  = 1'b0;
            req0_r_wb   = 1'($urandom);
            req0_addr   = 8'($urandom);
            req0_data_w = {$urandom, $urandom};
        end
        if (rst_n && q1.size() > 0) begin
            if (!req1_valid) load_cyc1 = cyc;
            req1_valid  = 1'b1;
            req1_r_wb   = q1[0].r_wb;
            req1_addr   = q1[0].addr;
            req1_data_w = q1[0].data;
        end else begin
            req1_valid  = 1'b0;
            req1_r_wb   = 1'($urandom);
            req1_addr   = 8'($urandom);
            req1_data_w = {$urandom, $urandom};
        end
    endtask

    task automatic runUntil(input int target);
        int n = 0;
        while (done_count < target && n < 2000) begin
            tick();
            n++;
        end
        checkOutput("run_budget", done_count, target);
    endtask

    task automatic waitBridgeIdle();
        int n = 0;
        while (bridge_busy && n < 200) begin
            tick();
            n++;
        end
        checkOutput("bridge_idle", bridge_busy, 0);
        tick();
    endtask

    task automatic resetModel();
        q0.delete();
        q1.delete();
        model_last  = 1'b1;
        txn_open    = 1'b0;
        resp_seen   = 1'b0;
        bridge_busy = 1'b0;
        exp_data_r0 = '0;
        exp_data_r1 = '0;
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctrl"}, {56'h0, req0_ack, req0_done, req0_err, req1_ack,
                                     req1_done, req1_err, C_in_valid, C_r_wb}, 0);
        checkOutput({tag, "_addr"}, {56'h0, C_addr}, 0);
        checkOutput({tag, "_cdw"}, C_data_w, 0);
        checkOutput({tag, "_data_r0"}, req0_data_r, 0);
        checkOutput({tag, "_data_r1"}, req1_data_r, 0);
    endtask

    initial begin
        logic [DATA_W-1:0] saved;
        int n;

        resetModel();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkAllZero("reset");
        tick();

        // Tie from reset: grants must alternate starting with req0.
        bridge_lat = 3;
        applyStimulus(0, 1, 8'h11, '0);
        applyStimulus(0, 1, 8'h12, '0);
        applyStimulus(1, 1, 8'h21, '0);
        applyStimulus(1, 1, 8'h22, '0);
        grant_log.delete();
        runUntil(4);
        checkOutput("fair_count", grant_log.size(), 4);
        if (grant_log.size() == 4)
            checkOutput("fair_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 4'b0101);
        waitBridgeIdle();

        // Single read from req0 with a known bridge response.
        bridge_lat  = 12;
        req1_pulses = 1'b0;
        applyStimulus(0, 1, 8'h05, '0);
        runUntil(done_count + 1);
        checkOutput("t1_ack_latency", ack_cyc0 - load_cyc0, 1);
        checkOutput("t1_data", req0_data_r, 64'hDEAD_BEEF_0000_0005);
        checkOutput("t1_req1_quiet", req1_pulses, 0);
        waitBridgeIdle();

        // Write from req1 leaves its read-data register alone.
        bridge_lat = 4;
        saved = exp_data_r1;
        applyStimulus(1, 0, 8'hFF, 64'h1234);
        runUntil(done_count + 1);
        checkOutput("t3_rwb", C_r_wb, 0);
        checkOutput("t3_cdw", C_data_w, 64'h1234);
        checkOutput("t3_data_r1", req1_data_r, saved);
        waitBridgeIdle();

        // Stalled bridge: req0 times out, req1 waits out the drain.
        bridge_lat = 30;
        n = timeouts;
        saved = exp_data_r0;
        applyStimulus(0, 1, 8'h40, '0);
        applyStimulus(1, 1, 8'h41, '0);
        runUntil(done_count + 2);
        checkOutput("to_count", timeouts - n, 2);
        checkOutput("to_ack1_after_drain", ack_gap1, 2);
        checkOutput("to_data_r0", req0_data_r, saved);
        waitBridgeIdle();

        // Randomised batches, random latencies including timeouts.
        salt_random = 1'b1;
        bridge_lat  = 0;
        for (int b = 0; b < 8; b++) begin
            int cnt;
            int target;
            cnt    = $urandom_range(1, 4);
            target = done_count + cnt;
            for (int k = 0; k < cnt; k++)
                applyStimulus(1'($urandom), 1'($urandom), 8'($urandom), {$urandom, $urandom});
            runUntil(target);
            waitBridgeIdle();
            repeat ($urandom_range(0, 3)) tick();
        end

        // Asynchronous reset in the middle of a write's WAIT phase.
        bridge_lat = 10;
        applyStimulus(0, 0, 8'h3C, {$urandom, 32'h1});
        n = 0;
        while (!txn_open && n < 50) begin
            tick();
            n++;
        end
        checkOutput("rst_setup_issue", txn_open, 1);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 checkAllZero("async_rst");
        resetModel();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bridge_lat = 5;
        applyStimulus(1, 1, 8'h77, '0);
        runUntil(done_count + 1);
        checkOutput("post_rst_ack_latency", ack_cyc1 - load_cyc1, 1);
        checkOutput("post_rst_err", timeouts, timeouts);
        waitBridgeIdle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
